// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types and widths for the RDB read response path.
package vector_cache_pkg;

  localparam int unsigned VC_RDB_DATA_WIDTH = 512;
  localparam int unsigned DB_ENTRY_IDX_WIDTH = 4;
  localparam int unsigned VC_TXNID_WIDTH = 8;
  localparam int unsigned VC_ROB_ID_WIDTH = 6;

  // Full response as buffered and returned to the upstream requester
  typedef struct packed {
    logic [VC_RDB_DATA_WIDTH-1:0]  data;
    logic [VC_TXNID_WIDTH-1:0]     txnid;
    logic [VC_ROB_ID_WIDTH-1:0]    rob_entry_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0] db_entry_id;
  } rdb_resp_t;

  // Sideband carried alongside an SRAM read while the data is in flight
  typedef struct packed {
    logic [VC_TXNID_WIDTH-1:0]     txnid;
    logic [VC_ROB_ID_WIDTH-1:0]    rob_entry_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0] db_entry_id;
  } rdb_side_t;

endpackage

// File: rtl/rdb_resp_fifo.sv
// Power-of-two circular response FIFO with occupancy count; the caller
// guarantees no push when full and no pop when empty.
module rdb_resp_fifo
  import vector_cache_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  rdb_resp_t                    push_data_i,
  input  logic                         pop_i,
  output rdb_resp_t                    head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  rdb_resp_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!push_i && pop_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/rdb_resp_egress.sv
// RDB read response egress: aligns sideband with SRAM data, buffers and returns
// responses to US with credit back-pressure. Optional macro RDB_RESP_BYPASS_EN.
module rdb_resp_egress
  import vector_cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = VC_RDB_DATA_WIDTH,
  parameter int unsigned DB_ID_WIDTH  = DB_ENTRY_IDX_WIDTH,
  parameter int unsigned TXNID_WIDTH  = VC_TXNID_WIDTH,
  parameter int unsigned ROB_ID_WIDTH = VC_ROB_ID_WIDTH,
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdb_mem_en,
  input  logic                    rdb_wr_en,
  input  logic [DB_ID_WIDTH-1:0]  rdb_db_entry_id,
  input  logic [TXNID_WIDTH-1:0]  rdb_txnid,
  input  logic [ROB_ID_WIDTH-1:0] rdb_rob_entry_id,
  output logic                    rdb_rdy,
  input  logic [DATA_WIDTH-1:0]   rdb_rd_data,
  output logic                    us_resp_vld,
  input  logic                    us_resp_rdy,
  output logic [DATA_WIDTH-1:0]   us_resp_data,
  output logic [TXNID_WIDTH-1:0]  us_resp_txnid,
  output logic                    to_us_done,
  output logic [ROB_ID_WIDTH-1:0] to_us_done_idx,
  output logic                    db_release_vld,
  output logic [DB_ID_WIDTH-1:0]  db_release_idx
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic             launch, pipe_out_vld, push, pop, handshake;
  logic [CNT_W-1:0] fifo_cnt, inflight_q, inflight_d;
  rdb_side_t        side_in;
  rdb_side_t        pipe_q [RD_LAT];
  logic [RD_LAT-1:0] pipe_vld_q;
  rdb_resp_t        pipe_resp, head, out_resp;

  assign launch = rdb_mem_en && !rdb_wr_en && rdb_rdy;

  always_comb begin
    side_in.txnid        = VC_TXNID_WIDTH'(rdb_txnid);
    side_in.rob_entry_id = VC_ROB_ID_WIDTH'(rdb_rob_entry_id);
    side_in.db_entry_id  = DB_ENTRY_IDX_WIDTH'(rdb_db_entry_id);
  end

  // Fixed-latency alignment pipe, never stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      pipe_q     <= '{default: '0};
    end else begin
      pipe_vld_q[0] <= launch;
      pipe_q[0]     <= side_in;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_q[i]     <= pipe_q[i-1];
      end
    end
  end

  assign pipe_out_vld = pipe_vld_q[RD_LAT-1];

  always_comb begin
    pipe_resp.data         = VC_RDB_DATA_WIDTH'(rdb_rd_data);
    pipe_resp.txnid        = pipe_q[RD_LAT-1].txnid;
    pipe_resp.rob_entry_id = pipe_q[RD_LAT-1].rob_entry_id;
    pipe_resp.db_entry_id  = pipe_q[RD_LAT-1].db_entry_id;
  end

`ifdef RDB_RESP_BYPASS_EN
  // Empty FIFO: present the aligned read directly; push only if US stalls
  logic bypass;
  assign bypass      = pipe_out_vld && (fifo_cnt == '0);
  assign push        = pipe_out_vld && !(bypass && us_resp_rdy);
  assign out_resp    = bypass ? pipe_resp : head;
  assign us_resp_vld = bypass || (fifo_cnt != '0);
`else
  assign push        = pipe_out_vld;
  assign out_resp    = head;
  assign us_resp_vld = (fifo_cnt != '0);
`endif

  assign handshake = us_resp_vld && us_resp_rdy;
  assign pop       = handshake && (fifo_cnt != '0);

  rdb_resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (pipe_resp),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_cnt)
  );

  always_comb begin
    inflight_d = inflight_q;
    if (launch && !pipe_out_vld) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!launch && pipe_out_vld) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  // Release pulses follow the US handshake by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q     <= '0;
      to_us_done     <= 1'b0;
      to_us_done_idx <= '0;
      db_release_vld <= 1'b0;
      db_release_idx <= '0;
    end else begin
      inflight_q     <= inflight_d;
      to_us_done     <= handshake;
      db_release_vld <= handshake;
      to_us_done_idx <= handshake ? ROB_ID_WIDTH'(out_resp.rob_entry_id) : '0;
      db_release_idx <= handshake ? DB_ID_WIDTH'(out_resp.db_entry_id) : '0;
    end
  end

  // Reserving FIFO space at launch means a push never finds the FIFO full
  assign rdb_rdy = (SUM_W'(inflight_q) + SUM_W'(fifo_cnt)) < SUM_W'(FIFO_DEPTH);

  assign us_resp_data  = DATA_WIDTH'(out_resp.data);
  assign us_resp_txnid = TXNID_WIDTH'(out_resp.txnid);

endmodule
